// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush control for the IITB-RISC 5-stage pipeline.
// Handles load-use bubbles, branch flushes and LM/SM micro-op sequencing.
module pipe_stall_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic       nop,
   input  logic       flush,
   input  logic       lmsm_start,
   input  logic [7:0] lmsm_mask,
   output logic       pc_en,
   output logic       if_id_en,
   output logic       id_rr_en,
   output logic       rr_ex_bubble,
   output logic       if_id_flush,
   output logic       id_rr_flush,
   output logic       lmsm_valid,
   output logic [2:0] lmsm_reg,
   output logic [2:0] lmsm_offset,
   output logic       lmsm_first,
   output logic       lmsm_last
);

   typedef enum logic [0:0] {IDLE = 1'b0, SEQ = 1'b1} state_t;

   state_t     state_r, state_s;
   logic [7:0] rem_mask_r, rem_mask_s;
   logic [2:0] offset_r, offset_s;
   logic       lu_block_r, lu_block_s;

   // Index of the lowest set bit; ascending register order R0 -> R7.
   function automatic logic [2:0] low_idx(input logic [7:0] m);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) idx = i[2:0];
         else      idx = idx;
      end
      return idx;
   endfunction

   function automatic logic multi_bit(input logic [7:0] m);
      return (m & (m - 8'd1)) != 8'd0;
   endfunction

   // Next-state and same-cycle control outputs.
   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_rr_en     = 1'b1;
      rr_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      id_rr_flush  = 1'b0;
      lmsm_valid   = 1'b0;
      lmsm_reg     = 3'd0;
      lmsm_offset  = 3'd0;
      lmsm_first   = 1'b0;
      lmsm_last    = 1'b0;
      state_s      = state_r;
      rem_mask_s   = rem_mask_r;
      offset_s     = offset_r;
      lu_block_s   = 1'b0;

      if (flush) begin
         if_id_flush  = 1'b1;
         id_rr_flush  = 1'b1;
         rr_ex_bubble = 1'b1;
         state_s      = IDLE;
         rem_mask_s   = 8'd0;
         offset_s     = 3'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (nop && !lu_block_r) begin
                  pc_en        = 1'b0;
                  if_id_en     = 1'b0;
                  id_rr_en     = 1'b0;
                  rr_ex_bubble = 1'b1;
                  lu_block_s   = 1'b1;
               end else if (lmsm_start && (lmsm_mask != 8'd0)) begin
                  lmsm_valid = 1'b1;
                  lmsm_first = 1'b1;
                  lmsm_reg   = low_idx(lmsm_mask);
                  if (multi_bit(lmsm_mask)) begin
                     pc_en      = 1'b0;
                     if_id_en   = 1'b0;
                     id_rr_en   = 1'b0;
                     rem_mask_s = lmsm_mask & (lmsm_mask - 8'd1);
                     offset_s   = 3'd1;
                     state_s    = SEQ;
                  end else begin
                     lmsm_last = 1'b1;
                  end
               end else begin
                  state_s = IDLE;
               end
            end
            SEQ: begin
               lmsm_valid  = 1'b1;
               lmsm_reg    = low_idx(rem_mask_r);
               lmsm_offset = offset_r;
               rem_mask_s  = rem_mask_r & (rem_mask_r - 8'd1);
               if (multi_bit(rem_mask_r)) begin
                  pc_en    = 1'b0;
                  if_id_en = 1'b0;
                  id_rr_en = 1'b0;
                  offset_s = offset_r + 3'd1;
               end else begin
                  // Return offset to 0 rather than letting 7 wrap.
                  lmsm_last = 1'b1;
                  offset_s  = 3'd0;
                  state_s   = IDLE;
               end
            end
            default: begin
               state_s    = IDLE;
               rem_mask_s = 8'd0;
               offset_s   = 3'd0;
            end
         endcase
      end
   end

   // State and sequencing registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         rem_mask_r <= 8'd0;
         offset_r   <= 3'd0;
         lu_block_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         rem_mask_r <= rem_mask_s;
         offset_r   <= offset_s;
         lu_block_r <= lu_block_s;
      end
   end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl.
// ctl packing: {pc_en,if_id_en,id_rr_en, rr_ex_bubble,if_id_flush,id_rr_flush, lmsm_valid,lmsm_first,lmsm_last}
module tb_pipe_stall_ctrl;

   logic       clk;
   logic       reset;
   logic       nop;
   logic       flush;
   logic       lmsm_start;
   logic [7:0] lmsm_mask;
   logic       pc_en, if_id_en, id_rr_en, rr_ex_bubble, if_id_flush, id_rr_flush;
   logic       lmsm_valid, lmsm_first, lmsm_last;
   logic [2:0] lmsm_reg, lmsm_offset;

   int n_checks;
   int n_fail;

   localparam logic [8:0] C_IDLE  = 9'b111_000_000;
   localparam logic [8:0] C_STALL = 9'b000_100_000;
   localparam logic [8:0] C_FLUSH = 9'b111_111_000;
   localparam logic [8:0] C_FIRST = 9'b000_000_110;
   localparam logic [8:0] C_MID   = 9'b000_000_100;
   localparam logic [8:0] C_LAST  = 9'b111_000_101;
   localparam logic [8:0] C_ONE   = 9'b111_000_111;

   pipe_stall_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .nop          (nop),
      .flush        (flush),
      .lmsm_start   (lmsm_start),
      .lmsm_mask    (lmsm_mask),
      .pc_en        (pc_en),
      .if_id_en     (if_id_en),
      .id_rr_en     (id_rr_en),
      .rr_ex_bubble (rr_ex_bubble),
      .if_id_flush  (if_id_flush),
      .id_rr_flush  (id_rr_flush),
      .lmsm_valid   (lmsm_valid),
      .lmsm_reg     (lmsm_reg),
      .lmsm_offset  (lmsm_offset),
      .lmsm_first   (lmsm_first),
      .lmsm_last    (lmsm_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic check_outs(input string tag, input logic [8:0] ectl,
                             input logic [2:0] ereg, input logic [2:0] eoff);
      check_val({tag, ".ctl"},
                {23'd0, pc_en, if_id_en, id_rr_en, rr_ex_bubble, if_id_flush,
                 id_rr_flush, lmsm_valid, lmsm_first, lmsm_last},
                {23'd0, ectl});
      check_val({tag, ".reg_off"}, {26'd0, lmsm_reg, lmsm_offset}, {26'd0, ereg, eoff});
   endtask

   // Drive one cycle of inputs at the falling edge, check combinational outputs 1ns later.
   task automatic cyc(input string tag, input logic n, input logic f, input logic s,
                      input logic [7:0] m, input logic [8:0] ectl,
                      input logic [2:0] ereg, input logic [2:0] eoff);
      @(negedge clk);
      nop = n; flush = f; lmsm_start = s; lmsm_mask = m;
      #1;
      check_outs(tag, ectl, ereg, eoff);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset = 1'b1; nop = 1'b0; flush = 1'b0; lmsm_start = 1'b0; lmsm_mask = 8'd0;
      #1;
      check_outs("reset", C_IDLE, 3'd0, 3'd0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      cyc("idle", 1'b0, 1'b0, 1'b0, 8'h00, C_IDLE, 3'd0, 3'd0);

      // Load-use: held nop gives exactly one bubble, then a fresh nop stalls again.
      cyc("lu.c1", 1'b1, 1'b0, 1'b0, 8'h00, C_STALL, 3'd0, 3'd0);
      cyc("lu.c2", 1'b1, 1'b0, 1'b0, 8'h00, C_IDLE,  3'd0, 3'd0);
      cyc("lu.gap", 1'b0, 1'b0, 1'b0, 8'h00, C_IDLE, 3'd0, 3'd0);
      cyc("lu.again", 1'b1, 1'b0, 1'b0, 8'h00, C_STALL, 3'd0, 3'd0);
      cyc("lu.rel", 1'b0, 1'b0, 1'b0, 8'h00, C_IDLE, 3'd0, 3'd0);

      // Mask 0x25 -> R0, R2, R5.
      cyc("m25.c1", 1'b0, 1'b0, 1'b1, 8'h25, C_FIRST, 3'd0, 3'd0);
      cyc("m25.c2", 1'b1, 1'b0, 1'b1, 8'h25, C_MID,   3'd2, 3'd1);
      cyc("m25.c3", 1'b0, 1'b0, 1'b1, 8'h25, C_LAST,  3'd5, 3'd2);
      cyc("m25.end", 1'b0, 1'b0, 1'b0, 8'h00, C_IDLE, 3'd0, 3'd0);

      // Mask 0xFF -> R0..R7, offsets 0..7.
      cyc("mff.c0", 1'b0, 1'b0, 1'b1, 8'hFF, C_FIRST, 3'd0, 3'd0);
      for (int i = 1; i < 7; i++)
         cyc($sformatf("mff.c%0d", i), 1'b0, 1'b0, 1'b0, 8'h00, C_MID, 3'(i), 3'(i));
      cyc("mff.c7", 1'b0, 1'b0, 1'b0, 8'h00, C_LAST, 3'd7, 3'd7);
      cyc("mff.end", 1'b0, 1'b0, 1'b0, 8'h00, C_IDLE, 3'd0, 3'd0);

      // Empty mask and single-bit mask.
      cyc("m00", 1'b0, 1'b0, 1'b1, 8'h00, C_IDLE, 3'd0, 3'd0);
      cyc("m80", 1'b0, 1'b0, 1'b1, 8'h80, C_ONE,  3'd7, 3'd0);
      cyc("m80.end", 1'b0, 1'b0, 1'b0, 8'h00, C_IDLE, 3'd0, 3'd0);

      // nop together with LM/SM 0x03: bubble first, then R0, R1.
      cyc("nl.c1", 1'b1, 1'b0, 1'b1, 8'h03, C_STALL, 3'd0, 3'd0);
      cyc("nl.c2", 1'b1, 1'b0, 1'b1, 8'h03, C_FIRST, 3'd0, 3'd0);
      cyc("nl.c3", 1'b0, 1'b0, 1'b0, 8'h00, C_LAST,  3'd1, 3'd1);
      cyc("nl.end", 1'b0, 1'b0, 1'b0, 8'h00, C_IDLE, 3'd0, 3'd0);

      // Mask 0xF0 aborted by flush on the second micro-op.
      cyc("fl.c1", 1'b0, 1'b0, 1'b1, 8'hF0, C_FIRST, 3'd4, 3'd0);
      cyc("fl.c2", 1'b0, 1'b1, 1'b0, 8'h00, C_FLUSH, 3'd0, 3'd0);
      cyc("fl.c3", 1'b0, 1'b0, 1'b0, 8'h00, C_IDLE,  3'd0, 3'd0);

      // Flush on the last SEQ cycle wins.
      cyc("fll.c1", 1'b0, 1'b0, 1'b1, 8'h03, C_FIRST, 3'd0, 3'd0);
      cyc("fll.c2", 1'b0, 1'b1, 1'b0, 8'h00, C_FLUSH, 3'd0, 3'd0);
      cyc("fll.c3", 1'b0, 1'b0, 1'b0, 8'h00, C_IDLE,  3'd0, 3'd0);

      // Flush beats nop in IDLE and does not arm lu_block.
      cyc("fn.c1", 1'b1, 1'b1, 1'b0, 8'h00, C_FLUSH, 3'd0, 3'd0);
      cyc("fn.c2", 1'b1, 1'b0, 1'b0, 8'h00, C_STALL, 3'd0, 3'd0);
      cyc("fn.c3", 1'b0, 1'b0, 1'b0, 8'h00, C_IDLE,  3'd0, 3'd0);

      // Asynchronous reset in the middle of a sequence.
      cyc("rs.c1", 1'b0, 1'b0, 1'b1, 8'h0F, C_FIRST, 3'd0, 3'd0);
      cyc("rs.c2", 1'b0, 1'b0, 1'b0, 8'h00, C_MID,   3'd1, 3'd1);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_outs("rs.async", C_IDLE, 3'd0, 3'd0);
      @(negedge clk);
      reset = 1'b0;
      cyc("rs.after", 1'b0, 1'b0, 1'b0, 8'h00, C_IDLE, 3'd0, 3'd0);
      cyc("rs.after2", 1'b0, 1'b0, 1'b0, 8'h00, C_IDLE, 3'd0, 3'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Pipeline control block that consumes the load-use stall request (`nop`) from the hazard detector and the LM/SM decode from the RR stage, and drives the register enables, bubble insertion and flush controls of the IITB-RISC 5-stage pipeline. It also sequences LM/SM into one register-transfer micro-op per set mask bit while freezing the front end. It sits between the hazard/branch logic and the PC, IF/ID, ID/RR and RR/EX pipeline registers.

## Interface
- No parameters.
- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `nop`  in  1  load-use stall request from hazard detector (combinational, same cycle).
- `flush`  in  1  taken branch/jump resolved in EX; squash younger stages.
- `lmsm_start`  in  1  instruction in RR stage is LM (0110) or SM (0111).
- `lmsm_mask`  in  8  immediate register mask of that instruction; bit i = Ri.
- `pc_en`  out  1  PC write enable.
- `if_id_en`  out  1  IF/ID register write enable.
- `id_rr_en`  out  1  ID/RR register write enable.
- `rr_ex_bubble`  out  1  load NOP into RR/EX this cycle.
- `if_id_flush`, `id_rr_flush`  out  1 each  clear valid of those registers.
- `lmsm_valid`  out  1  RR/EX receives an LM/SM micro-op this cycle.
- `lmsm_reg`  out  3  register index of current micro-op.
- `lmsm_offset`  out  3  transfer count before this micro-op (address = base + offset).
- `lmsm_first`, `lmsm_last`  out  1 each  first / last micro-op markers.

## Operation
- State: `IDLE`, `SEQ`; registers `rem_mask[7:0]`, `offset[2:0]`, `lu_block`.
- Outputs are combinational from state, registers and inputs. Default: all enables 1, all other outputs 0.
- Priority per cycle: `flush` > `nop` (IDLE only) > `lmsm_start` (IDLE only).
- Flush (any state): `if_id_flush=id_rr_flush=1`, `rr_ex_bubble=1`, enables 1, `lmsm_valid=0`; next state `IDLE`, `rem_mask=0`, `offset=0`, `lu_block=0`. An in-progress LM/SM is aborted.
- Load-use (IDLE, `nop=1`, `lu_block=0`): `pc_en=if_id_en=id_rr_en=0`, `rr_ex_bubble=1`, set `lu_block`. `lu_block` clears next cycle; `nop` is ignored while `lu_block=1`, so one request yields exactly one bubble.
- LM/SM start (IDLE, `lmsm_start=1`, not stalled):
  - mask 0: no micro-op, `lmsm_valid=0`, pipeline advances normally.
  - else: `lmsm_valid=1`, `lmsm_first=1`, `lmsm_reg`= lowest set bit, `lmsm_offset=0`.
  - popcount 1: `lmsm_last=1`, enables 1, stay `IDLE`.
  - popcount >1: `pc_en=if_id_en=id_rr_en=0`; latch `rem_mask` = mask with lowest bit cleared; `offset=1`; go `SEQ`.
- SEQ, each cycle: `lmsm_valid=1`, `lmsm_reg`= lowest set bit of `rem_mask`, `lmsm_offset=offset`; clear that bit; `offset+1`.
  - If exactly one bit remains: `lmsm_last=1`, enables 1 this cycle, next `IDLE`.
  - Otherwise enables 0.
  - `nop` and `lmsm_start` are ignored.
- Register order is ascending R0→R7. `offset` never wraps, max 7 at mask 0xFF.

## Timing
- Reset (async): state `IDLE`, `rem_mask=0`, `offset=0`, `lu_block=0`. With inputs at 0, outputs are `pc_en=if_id_en=id_rr_en=1`, all others 0, `lmsm_reg=0`, `lmsm_offset=0`.
- Stall, bubble and flush outputs respond in the same cycle as their inputs (zero latency).
- A load-use stall costs exactly 1 cycle.
- LM/SM with popcount N≥1 occupies N cycles, front end frozen for N−1 cycles.
- `nop` and `lmsm_start` in the same cycle: bubble first. The LM/SM stays in RR (frozen) and its sequence starts the following cycle (`lu_block=1` then).
- Flush in the last SEQ cycle: flush wins; `lmsm_valid=0`.
- Reset asserted mid-SEQ: immediate return to `IDLE` defaults. Remaining micro-ops are dropped.

## Test plan
- Reset then idle inputs -> `pc_en=if_id_en=id_rr_en=1`, all other outputs 0.
- `nop=1` held 2 cycles -> cycle 1: enables 0, `rr_ex_bubble=1`; cycle 2: enables 1, `rr_ex_bubble=0`.
- `lmsm_start=1`, mask 0x25 -> 3 cycles `lmsm_reg`=0,2,5, `lmsm_offset`=0,1,2, first on cycle 1, last on cycle 3; enables 0 on cycles 1–2, 1 on cycle 3.
- Mask 0xFF -> 8 micro-ops R0..R7, offsets 0..7. Mask 0x00 -> `lmsm_valid` never 1, no stall. Mask 0x80 -> single cycle, first=last=1, reg 7.
- `nop` and `lmsm_start` (mask 0x03) together -> 1 bubble cycle, then micro-ops R0, R1 on the next two cycles.
- Mask 0xF0, `flush` on the 2nd micro-op cycle -> that cycle: `lmsm_valid=0`, both flushes 1, `rr_ex_bubble=1`; next cycle `IDLE`, no further micro-ops.
